// File: rtl/dense_layer_seq_pkg.sv
// Shared definitions for the dense-layer sequencer.
// Holds the default layer geometry, the accumulator type and the
// sequencer state encoding used by dense_layer_seq and its lanes.
package dense_layer_seq_pkg;

    // Default geometry of the layer this sequencer is built for
    localparam int IN_SIZE_0  = 32;
    localparam int OUT_SIZE_0 = 3;
    localparam int IN_W_0     = 40;
    localparam int W_W_0      = 8;
    localparam int ACC_W_0    = 48;
    localparam int IDX_W_0    = 8;

    typedef logic signed [ACC_W_0-1:0] acc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/dense_layer_seq_sat_mac_lane.sv
// One accumulator lane of the dense layer: loads the sign-extended bias,
// then adds data*weight with saturation whenever enabled.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load bias into the accumulator (wins over en)
//   en           accumulate this cycle's product
//   bias         signed bias for this lane
//   data         signed input element
//   weight       signed weight for this lane
//   acc_next     saturated accumulator + product (value written when en)
module sat_mac_lane
    import dense_layer_seq_pkg::*;
#(
    parameter int IN_W  = IN_W_0,
    parameter int W_W   = W_W_0,
    parameter int ACC_W = ACC_W_0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [W_W-1:0]   bias,
    input  logic signed [IN_W-1:0]  data,
    input  logic signed [W_W-1:0]   weight,
    output logic signed [ACC_W-1:0] acc_next
);

    localparam int PROD_W = IN_W + W_W;
    // One guard bit is enough: the product never exceeds the accumulator range
    localparam int SUM_W  = ACC_W + 1;

    // Clamp a one-bit-wide-overflow sum back into the accumulator range
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v[SUM_W-1] != v[SUM_W-2]) begin
            r = v[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    logic signed [ACC_W-1:0]  acc_r;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [SUM_W-1:0]  sum_s;

    // Full-precision product and guarded sum, then saturate
    always_comb begin
        prod_s   = PROD_W'(data) * PROD_W'(weight);
        sum_s    = SUM_W'(acc_r) + SUM_W'(prod_s);
        acc_next = saturate(sum_s);
    end

    // Accumulator register: bias load has priority over accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (load) begin
            acc_r <= ACC_W'(bias);
        end else if (en) begin
            acc_r <= acc_next;
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequencer for one fully-connected layer. Walks the input vector one
// element per cycle, pairs each element with its registered ROM row one
// cycle later, and accumulates into OUT_SIZE saturating lanes.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort, busy  run control (start sampled only when idle)
//   in_idx, in_data     index into / element of the caller's input vector
//   w_addr, w_row       weight ROM address and the row it returns next cycle
//   bias                per-lane bias, static during a run
//   out_valid, out_ready, out_vec  result handshake and packed result
module dense_layer_seq
    import dense_layer_seq_pkg::*;
#(
    parameter int IN_SIZE  = IN_SIZE_0,
    parameter int OUT_SIZE = OUT_SIZE_0,
    parameter int IN_W     = IN_W_0,
    parameter int W_W      = W_W_0,
    parameter int ACC_W    = ACC_W_0,
    parameter int IDX_W    = IDX_W_0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic [IDX_W-1:0]          in_idx,
    input  logic [IN_W-1:0]           in_data,
    output logic [IDX_W-1:0]          w_addr,
    input  logic [OUT_SIZE*W_W-1:0]   w_row,
    input  logic [OUT_SIZE*W_W-1:0]   bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_SIZE*ACC_W-1:0] out_vec
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);

    seq_state_t state_r, state_nxt;
    logic busy_r, busy_nxt;
    logic valid_r, valid_nxt;
    logic load_bias_s, issue_s, capture_s;
    logic [IDX_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          idx_r;
    logic [IN_W-1:0]           p_data_r;
    logic                      p_vld_r;
    logic [OUT_SIZE*ACC_W-1:0] out_vec_r;
    logic [OUT_SIZE*ACC_W-1:0] acc_next_s;

    // State register plus the registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= busy_nxt;
            valid_r <= valid_nxt;
        end
    end

    // Next-state logic; abort overrides everything once a run is in flight
    always_comb begin
        state_nxt = state_r;
        if (abort && (state_r != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt = start ? ST_LOAD : ST_IDLE;
                ST_LOAD:  state_nxt = ST_ISSUE;
                ST_ISSUE: state_nxt = (cnt_r == LAST_IDX) ? ST_DRAIN : ST_ISSUE;
                ST_DRAIN: state_nxt = ST_DONE;
                ST_DONE:  state_nxt = out_ready ? ST_IDLE : ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output/control decode from current and next state
    always_comb begin
        busy_nxt    = (state_nxt != ST_IDLE);
        valid_nxt   = (state_nxt == ST_DONE);
        load_bias_s = (state_r == ST_IDLE) && start;
        issue_s     = (state_r == ST_ISSUE) && !abort;
        capture_s   = (state_r == ST_DRAIN) && !abort;
    end

    // Issue counter, index output, input pipeline register and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {IDX_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            p_data_r  <= {IN_W{1'b0}};
            p_vld_r   <= 1'b0;
            out_vec_r <= {(OUT_SIZE*ACC_W){1'b0}};
        end else begin
            p_vld_r <= issue_s;
            if (issue_s) begin
                p_data_r <= in_data;
            end
            if (load_bias_s) begin
                cnt_r <= {IDX_W{1'b0}};
            end else if (issue_s) begin
                cnt_r <= cnt_r + IDX_W'(1);
            end
            // idx_r mirrors cnt_r during ISSUE but holds its last value elsewhere
            if ((state_r == ST_LOAD) && !abort) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (issue_s && (cnt_r != LAST_IDX)) begin
                idx_r <= cnt_r + IDX_W'(1);
            end
            // The last MAC lands at the end of DRAIN, so capture the lane's next value
            if (capture_s) begin
                out_vec_r <= acc_next_s;
            end
        end
    end

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
        sat_mac_lane #(
            .IN_W  (IN_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load_bias_s),
            .en       (p_vld_r),
            .bias     (bias[j*W_W +: W_W]),
            .data     (p_data_r),
            .weight   (w_row[j*W_W +: W_W]),
            .acc_next (acc_next_s[j*ACC_W +: ACC_W])
        );
    end

    assign busy      = busy_r;
    assign out_valid = valid_r;
    assign in_idx    = idx_r;
    assign w_addr    = idx_r;
    assign out_vec   = out_vec_r;

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
Sequencer and accumulator for one fully-connected layer of the speech-recognition network. It walks the input vector one element per cycle, fetches the matching weight row from a registered weight ROM, and MACs into OUT_SIZE parallel saturating accumulators. Bias is added exactly once. It sits between the previous layer's output register and the next layer or argmax stage, with a start/busy and valid/ready handshake.

Parameters:
IN_SIZE, 32, number of input elements (ROM rows)
OUT_SIZE, 3, number of outputs / accumulator lanes
IN_W, 40, signed input element width
W_W, 8, signed weight and bias width
ACC_W, 48, signed accumulator/output width
IDX_W, 8, index/address width, must satisfy IDX_W >= clog2(IN_SIZE)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin layer computation; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE, discard result
busy  out  1  high in LOAD/ISSUE/DRAIN/DONE
in_idx  out  IDX_W  index into caller's input vector
in_data  in  IN_W  input_vector[in_idx], combinational from caller
w_addr  out  IDX_W  weight ROM row address (equals in_idx)
w_row  in  OUT_SIZE*W_W  ROM row, lane j at bits [j*W_W +: W_W], valid one cycle after w_addr
bias  in  OUT_SIZE*W_W  bias per lane, static during a run
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_vec  out  OUT_SIZE*ACC_W  lane j at [j*ACC_W +: ACC_W]

Behaviour:
- Reset (async): state=IDLE; busy, out_valid, in_idx, w_addr, cnt, pipe valid = 0; out_vec and all accumulators = 0.
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE: if start, then acc[j] <= sign-extended bias[j], cnt <= 0, go LOAD. Otherwise hold.
- LOAD: single cycle; go ISSUE. Exists to register bias separately from the first MAC.
- ISSUE: in_idx = w_addr = cnt. Each edge: p_data <= in_data, p_vld <= 1, cnt++. After cnt == IN_SIZE-1 has been issued, go DRAIN.
- MAC stage runs in any state whenever p_vld. acc[j] <= sat(acc[j] + p_data * w_row[j]). The product is a full IN_W+W_W signed value, and the sum is computed 1 bit wider than ACC_W. Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. p_vld clears when ISSUE ends.
- DRAIN: single cycle; the last MAC completes at its end. Then out_vec <= acc, out_valid <= 1, go DONE.
- DONE: out_valid held, out_vec stable. On out_valid && out_ready: out_valid <= 0, go IDLE. start is ignored in DONE.
- Latency: start high in cycle 0 gives out_valid in cycle IN_SIZE+3 (35 for defaults), assuming out_ready was not low earlier. One layer per IN_SIZE+4 cycles minimum.
- abort: in any non-IDLE state it wins over all else. Next state is IDLE, out_valid <= 0, p_vld <= 0. out_vec retains its previous value.
- start while busy: ignored, no effect.
- in_idx/w_addr hold their last value outside ISSUE.
- Reset mid-run: immediate return to the reset values above. Next start begins a clean run.

Decomposition:
- nn_parameters package: per-layer sizes (IN_SIZE_n, OUT_SIZE_n), acc_t (signed ACC_W), sequencer state enum.
- ROM contents stay outside this block.
- Sub-module sat_mac_lane: one lane with load-bias, enable, and saturating accumulate. Instantiate OUT_SIZE times via generate.

Test Plan:
- Basic sum: all inputs=1, all weights=1, bias={24,24,-52}, start at cycle 0 -> out_valid in cycle 35, out_vec={56,56,-20}, busy falls after handshake.
- Bias once: inputs=0, bias={24,24,-52} -> out_vec={24,24,-52}. A bias-per-step bug would give 32x.
- Saturation: inputs=2^39-1, weights=127 -> every lane = 2^47-1. Inputs=-2^39, weights=127 -> every lane = -2^47.
- Back-pressure: out_ready low for 10 cycles after out_valid -> out_valid and out_vec stable, start pulses ignored. out_ready high -> IDLE next cycle.
- Abort: assert abort in cycle 10 -> IDLE in cycle 11, no out_valid. Immediate restart gives the same result as the basic sum scenario.
- Async reset at cycle 20 mid-ISSUE -> outputs zero without a clock edge. Subsequent run is correct. Monitor that the in_idx sequence is 0..31 exactly once per run.
